// File: rtl/cmp16_pkg.sv
// Shared definitions for the 16-bit comparator byte loader.
//   DATA_W / OPND_W : byte-bus and operand widths
//   op_e            : comparison select encoding carried on in_op
//   state_e         : loader FSM states
package cmp16_pkg;

  localparam int DATA_W = 8;
  localparam int OPND_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_GE = 2'b00,
    OP_GT = 2'b01,
    OP_EQ = 2'b10,
    OP_LT = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_A0  = 3'd0,
    S_A1  = 3'd1,
    S_B0  = 3'd2,
    S_B1  = 3'd3,
    S_CMP = 3'd4,
    S_OUT = 3'd5
  } state_e;

endpackage

// File: rtl/cmp16_core.sv
// Combinational magnitude comparator.
//   i_a, i_b : operands (W bits, unsigned)
//   o_eq     : i_a == i_b
//   o_gt     : i_a >  i_b
// Built as a MSB-first priority chain: a bit decides "greater" only while
// every more-significant bit pair has compared equal.
module cmp16_core #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_gt
);

  logic [W-1:0] w_bit_eq;
  logic         w_eq_above;
  logic         w_gt;

  assign w_bit_eq = i_a ~^ i_b;

  always_comb begin
    w_eq_above = 1'b1;
    w_gt       = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      w_gt       = w_gt | (w_eq_above & i_a[i] & ~i_b[i]);
      w_eq_above = w_eq_above & w_bit_eq[i];
    end
  end

  assign o_eq = w_eq_above;
  assign o_gt = w_gt;

endmodule

// File: rtl/cmp16_byte_loader.sv
// Operand-assembly and result-register stage for the 16-bit comparator.
// Collects A_lo, A_hi, B_lo, B_hi from the byte bus (valid/ready), compares
// the latched operands for one cycle, then holds the result until taken.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    byte-bus handshake, in_data operand byte
//   in_op                comparison select, sampled with A_lo
//   in_signed            (CMP_SIGNED_EN only) signed compare, sampled with A_lo
//   abort                synchronous flush of the current transaction
//   out_valid/out_ready  result handshake
//   resultado            selected comparison outcome
//   eq_flag, gt_flag     A == B, A > B
//
// Build option: define CMP_SIGNED_EN to add the in_signed port and two's
// complement comparison. Without it all comparisons are unsigned.
//
// state | meaning
// S_A0  | waiting for A[7:0] (and in_op)
// S_A1  | waiting for A[15:8]
// S_B0  | waiting for B[7:0]
// S_B1  | waiting for B[15:8]
// S_CMP | comparator evaluates latched operands, result registered
// S_OUT | result held on outputs until out_ready
module cmp16_byte_loader #(
  parameter int DATA_W = cmp16_pkg::DATA_W,
  parameter int OPND_W = cmp16_pkg::OPND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_op,
`ifdef CMP_SIGNED_EN
  input  logic              in_signed,
`endif
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              resultado,
  output logic              eq_flag,
  output logic              gt_flag
);

  import cmp16_pkg::*;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [OPND_W-1:0] r_a;
  logic [OPND_W-1:0] r_b;
  op_e               r_op;
  logic              r_res;
  logic              r_eq;
  logic              r_gt;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_sign_sel;
  logic [OPND_W-1:0] w_a_cmp;
  logic [OPND_W-1:0] w_b_cmp;
  logic              w_eq;
  logic              w_gt;
  logic              w_res;

`ifdef CMP_SIGNED_EN
  logic r_signed;
  assign w_sign_sel = r_signed;
`else
  assign w_sign_sel = 1'b0;
`endif

  assign w_in_ready = (r_state == S_A0) || (r_state == S_A1) ||
                      (r_state == S_B0) || (r_state == S_B1);
  // A byte offered alongside abort is dropped.
  assign w_accept   = in_valid & w_in_ready & ~abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_A0:    if (w_accept) w_state_nxt = S_A1;
      S_A1:    if (w_accept) w_state_nxt = S_B0;
      S_B0:    if (w_accept) w_state_nxt = S_B1;
      S_B1:    if (w_accept) w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = S_A0;
      default: w_state_nxt = S_A0;
    endcase
    if (abort) begin
      w_state_nxt = S_A0;
    end
  end

  // Operand byte registers; loaded only on a handshake so undriven in_data
  // never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_GE;
`ifdef CMP_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else if (abort) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_GE;
`ifdef CMP_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else if (w_accept) begin
      case (r_state)
        S_A0: begin
          r_a[DATA_W-1:0] <= in_data;
          r_op            <= op_e'(in_op);
`ifdef CMP_SIGNED_EN
          r_signed        <= in_signed;
`endif
        end
        S_A1:    r_a[OPND_W-1:DATA_W] <= in_data;
        S_B0:    r_b[DATA_W-1:0]      <= in_data;
        S_B1:    r_b[OPND_W-1:DATA_W] <= in_data;
        default: ;
      endcase
    end
  end

  // Flipping both sign bits maps two's complement order onto unsigned order;
  // equality is unchanged by the flip.
  assign w_a_cmp = {r_a[OPND_W-1] ^ w_sign_sel, r_a[OPND_W-2:0]};
  assign w_b_cmp = {r_b[OPND_W-1] ^ w_sign_sel, r_b[OPND_W-2:0]};

  cmp16_core #(
    .W (OPND_W)
  ) u_core (
    .i_a  (w_a_cmp),
    .i_b  (w_b_cmp),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  always_comb begin
    w_res = 1'b0;
    case (r_op)
      OP_GE:   w_res = w_gt | w_eq;
      OP_GT:   w_res = w_gt;
      OP_EQ:   w_res = w_eq;
      OP_LT:   w_res = ~(w_gt | w_eq);
      default: w_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= 1'b0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
    end else if (abort) begin
      r_res <= 1'b0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
    end else if (r_state == S_CMP) begin
      r_res <= w_res;
      r_eq  <= w_eq;
      r_gt  <= w_gt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_OUT);
  assign resultado = r_res;
  assign eq_flag   = r_eq;
  assign gt_flag   = r_gt;

endmodule

// File: tb/tb_cmp16_byte_loader.sv
// Directed bench for cmp16_byte_loader. Expected results come from a
// behavioural model, are queued when a transaction is driven and popped when
// out_valid appears. Inputs change and outputs are sampled on the falling edge.
module tb_cmp16_byte_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_op;
`ifdef CMP_SIGNED_EN
  logic       in_signed;
`endif
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic       resultado;
  logic       eq_flag;
  logic       gt_flag;

  typedef struct packed {
    logic res;
    logic eq;
    logic gt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cmp16_byte_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
`ifdef CMP_SIGNED_EN
    .in_signed (in_signed),
`endif
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .resultado (resultado),
    .eq_flag   (eq_flag),
    .gt_flag   (gt_flag)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] op, input logic sgn);
    exp_t r;
    logic g;
    logic e;
    e = (a == b);
    g = sgn ? ($signed(a) > $signed(b)) : (a > b);
    case (op)
      2'b00:   r.res = g | e;
      2'b01:   r.res = g;
      2'b10:   r.res = e;
      default: r.res = ~(g | e);
    endcase
    r.eq = e;
    r.gt = g;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic [1:0] op);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $error("FAIL in_ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
    in_op    = 2'b00;
  endtask

  task automatic send_txn(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic sgn);
`ifdef CMP_SIGNED_EN
    in_signed = sgn;
`endif
    send_byte(a[7:0], op);
    send_byte(a[15:8], 2'b00);
    send_byte(b[7:0], 2'b00);
    send_byte(b[15:8], 2'b00);
  endtask

  // Drives one transaction, checks latency and result, then holds out_ready
  // low for 'hold' cycles checking the outputs stay put.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic sgn,
                        input int hold, input string tag);
    exp_t e;
    sb_q.push_back(model(a, b, op, sgn));
    send_txn(a, b, op, sgn);
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_inready_out"}, in_ready, 0);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_res"}, resultado, e.res);
      check({tag, "_eq"},  eq_flag,   e.eq);
      check({tag, "_gt"},  gt_flag,   e.gt);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_ready"}, in_ready, 0);
        check({tag, "_hold_flags"}, {resultado, eq_flag, gt_flag}, e);
      end
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rop;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_op     = 2'b00;
    abort     = 1'b0;
    out_ready = 1'b0;
`ifdef CMP_SIGNED_EN
    in_signed = 1'b0;
`endif

    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags",     {resultado, eq_flag, gt_flag}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready",  in_ready,  1);
    check("post_rst_out_valid", out_valid, 0);

    do_txn(16'h1234, 16'h1234, 2'b00, 1'b0, 0, "ge_equal");
    consume("ge_equal");

    // Reset while in S_CMP: outputs still hold the previous (1,1,0) result.
    send_txn(16'h4321, 16'h1234, 2'b01, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready",  in_ready,  1);
    check("async_rst_flags",     {resultado, eq_flag, gt_flag}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(16'h4321, 16'h1234, 2'b01, 1'b0, 0, "after_rst");
    consume("after_rst");

    do_txn(16'h00FF, 16'h0100, 2'b11, 1'b0, 0, "lt_true");
    consume("lt_true");
    do_txn(16'h00FF, 16'h0100, 2'b01, 1'b0, 5, "gt_false_bp");
    consume("gt_false_bp");

    // Abort after A_hi, with a byte offered in the abort cycle.
    send_byte(8'hFF, 2'b00);
    send_byte(8'hFF, 2'b00);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 'x;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready",  in_ready,  1);
    do_txn(16'h0001, 16'h0000, 2'b01, 1'b0, 0, "after_abort");
    consume("after_abort");

    // Abort in idle has no effect on the next transaction.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    do_txn(16'h8000, 16'h7FFF, 2'b01, 1'b0, 0, "msb_gt");
    consume("msb_gt");

    // Abort while the result is waiting drops it.
    do_txn(16'h1234, 16'h1235, 2'b11, 1'b0, 0, "lsb_lt");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_out_drop_valid", out_valid, 0);
    check("abort_out_drop_ready", in_ready,  1);

    do_txn(16'hA5A5, 16'hA5A4, 2'b10, 1'b0, 0, "eq_false");
    consume("eq_false");
    do_txn(16'hFFFF, 16'hFFFF, 2'b10, 1'b0, 2, "eq_true");
    consume("eq_true");

    for (int i = 0; i < 6; i++) begin
      ra  = 16'($urandom);
      rb  = (i % 3 == 0) ? ra : 16'($urandom);
      rop = 2'($urandom_range(3, 0));
      do_txn(ra, rb, rop, 1'b0, i % 2, "rand");
      consume("rand");
    end

`ifdef CMP_SIGNED_EN
    do_txn(16'hFFFF, 16'h0001, 2'b00, 1'b1, 0, "signed_ge");
    consume("signed_ge");
    do_txn(16'hFFFF, 16'h0001, 2'b00, 1'b0, 0, "unsigned_ge");
    consume("unsigned_ge");
    do_txn(16'h8000, 16'h7FFF, 2'b01, 1'b1, 0, "signed_gt");
    consume("signed_gt");
`endif

    check("sb_drained", 16'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
